uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Receive-side controller placed between the 16x-oversampling UART receiver and the APB register block. It gates the receiver output with an enable, buffers accepted bytes in a show-ahead FIFO, and drops frames flagged with errors. It also tracks overrun and error statistics and raises threshold and character-timeout interrupts for the APB side.

## Interface
- DATA_WIDTH, 8, receiver data width
- FIFO_DEPTH, 16, FIFO entries; power of 2, ≥2
- TIMEOUT_TICKS, 640, baud_en_16x ticks of RX idle before timeout (4 chars × 10 bits × 16)
- ERR_CNT_WIDTH, 8, error counter width
- clk  in  1  system clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- baud_en_16x  in  1  16x baud tick, one clk wide
- rx_en  in  1  receive enable (APB control bit)
- flush  in  1  one-cycle FIFO flush request
- clr_status  in  1  one-cycle clear of sticky flags, err_cnt and irq_timeout
- thresh  in  $clog2(FIFO_DEPTH)+1  irq_thresh level; 0 disables
- rx_data  in  DATA_WIDTH  receiver data, valid with rx_ready
- rx_ready  in  1  receiver frame-done pulse
- rx_error  in  1  receiver error level; high through the end of the errored frame
- rx_busy  in  1  receiver mid-frame
- rd_en  in  1  pop request from APB read of the data register
- rd_data  out  DATA_WIDTH  FIFO head; valid when fifo_empty=0
- fifo_empty  out  1  FIFO empty
- fifo_full  out  1  FIFO full
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy, 0..FIFO_DEPTH
- irq_thresh  out  1  fifo_level ≥ thresh, with thresh ≠ 0
- irq_timeout  out  1  character-timeout interrupt
- overrun  out  1  sticky; byte dropped because the FIFO was full
- err_sticky  out  1  sticky; receiver error seen
- err_cnt  out  ERR_CNT_WIDTH  saturating receiver error count

## Operation
- Control FSM, 3 states:
  - OFF: reset state.
    - Leaves to IDLE when rx_en=1 and rx_busy=0, so a frame already in progress at enable is never accepted.
  - IDLE: rx_en=1 and receiver idle.
    - rx_busy=1 → RECV.
    - rx_en=0 → OFF.
  - RECV: frame in progress.
    - Leaves to IDLE on rx_ready or when rx_busy falls.
    - rx_en=0 → OFF immediately; that frame's rx_ready is ignored.
- Push condition: state ≠ OFF and rx_ready=1 and rx_error=0. Every other rx_ready pulse is discarded.
- Error events:
  - Detected on a rising edge of rx_error, using a registered copy of rx_error, while state ≠ OFF.
  - Each event sets err_sticky and increments err_cnt; err_cnt saturates at all-ones.
- FIFO pointer rules:
  - Read and write pointers are $clog2(FIFO_DEPTH)+1 bits with a wrap bit.
  - Full = addresses equal and wrap bits differ.
  - fifo_level = wr_ptr − wr_ptr... computed as wr_ptr − rd_ptr, modulo 2^(width).
- Simultaneous push and pop:
  - When full: both occur, level unchanged, no overrun.
  - When empty: only the push occurs, since the pop is ignored.
- Push while full with no pop: byte dropped, overrun set. rd_en while empty: ignored.
- flush:
  - Resets both pointers.
  - Overrides a push or pop in the same cycle.
  - Clears irq_timeout.
  - Does not clear overrun, err_sticky or err_cnt.
- clr_status:
  - Clears overrun, err_sticky, err_cnt and irq_timeout.
  - An error or overrun event in the same cycle wins: flag set, err_cnt = 1.
- Timeout counter, counting up to TIMEOUT_TICKS:
  - Counts baud_en_16x ticks while state = IDLE and fifo_empty=0.
  - Reset to 0 on push, pop, flush, state ≠ IDLE, or fifo_empty=1.
  - On reaching TIMEOUT_TICKS it sets irq_timeout and holds its value until reset.
  - irq_timeout clears on pop, flush or clr_status.
- rx_en=0 retains FIFO contents; they remain readable.

## Timing
- Reset values:
  - fifo_empty=1.
  - All other outputs 0, including rd_data=0.
  - FSM in OFF; pointers and counters 0.
- rx_ready at cycle N → rd_data, fifo_level and fifo_empty update at N+1.
- rd_en at N → next head on rd_data at N+1. rd_data is combinational from the head entry.
- Error event: rx_error rising at N → err_cnt and err_sticky update at N+1.
- irq_thresh is combinational from the registered fifo_level and thresh.
- irq_timeout rises 1 clk after the TIMEOUT_TICKS-th qualifying tick.
- Asynchronous reset mid-frame: everything returns to reset values immediately. The first frame accepted afterwards is the first one that begins after rx_en is seen with rx_busy=0.

## Structure
- Shared package uart_pkg:
  - Control state encodings: OFF, IDLE, RECV.
  - Default DATA_WIDTH and FIFO_DEPTH constants.
  - Pointer-width function $clog2(FIFO_DEPTH)+1.
- One sub-module, uart_sync_fifo:
  - Parameterized DATA_WIDTH and FIFO_DEPTH, show-ahead.
  - Ports: push, pop, flush, wdata, rdata, empty, full, level.
- FSM, error, overrun and timeout logic stay in uart_rx_ctrl.

## Test plan
- rx_en=1; three rx_ready pulses with 0x55, 0xA3, 0x0F → fifo_level=3; rd_data=0x55 and reads return 0x55, 0xA3, 0x0F; fifo_empty=1 after the third rd_en.
- FIFO_DEPTH=16; 17 pushes with no pops → fifo_full=1, overrun=1, 17th byte absent. Then push and pop in the same cycle while full → level stays 16, no new overrun.
- Errors:
  - rx_error high across one rx_ready carrying 0xFF → no push, err_cnt=1, err_sticky=1.
  - 300 errored frames with ERR_CNT_WIDTH=8 → err_cnt=255.
  - clr_status → all cleared.
- One byte in FIFO, receiver idle, TIMEOUT_TICKS=640:
  - irq_timeout rises after tick 640.
  - Any push or rd_en before tick 640 restarts the count.
  - rd_en after assertion clears irq_timeout.
- Enable and flush boundaries:
  - rx_en raised while rx_busy=1 → that frame's rx_ready (data 0x3C) is not pushed; the next frame is pushed.
  - rx_en dropped mid-frame → no push.
  - flush in the same cycle as rx_ready → fifo_empty=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_IDLE = 2'd1,
        ST_RECV = 2'd2
    } ctrl_state_t;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_FIFO_DEPTH = 16;

    // Pointer width including the wrap bit.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers and flush.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int unsigned PTR_W      = ptr_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  empty,
    output logic                  full,
    output logic [PTR_W-1:0]      level
);

    localparam int unsigned ADDR_W = PTR_W - 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                   (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
    assign level = wr_ptr - rd_ptr;

    // A pop frees a slot in the same cycle, so push-while-full succeeds with a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[ADDR_W-1:0]] <= wdata;
    end

    // Head is forced to zero while empty so the post-reset value is defined.
    assign rdata = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: enable gating, FIFO buffering, error/overrun stats, interrupts.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter  int unsigned FIFO_DEPTH    = DEF_FIFO_DEPTH,
    parameter  int unsigned TIMEOUT_TICKS = 640,
    parameter  int unsigned ERR_CNT_WIDTH = 8,
    localparam int unsigned LVL_W         = ptr_width(FIFO_DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     baud_en_16x,
    input  logic                     rx_en,
    input  logic                     flush,
    input  logic                     clr_status,
    input  logic [LVL_W-1:0]         thresh,
    input  logic [DATA_WIDTH-1:0]    rx_data,
    input  logic                     rx_ready,
    input  logic                     rx_error,
    input  logic                     rx_busy,
    input  logic                     rd_en,
    output logic [DATA_WIDTH-1:0]    rd_data,
    output logic                     fifo_empty,
    output logic                     fifo_full,
    output logic [LVL_W-1:0]         fifo_level,
    output logic                     irq_thresh,
    output logic                     irq_timeout,
    output logic                     overrun,
    output logic                     err_sticky,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_TICKS + 1);

    ctrl_state_t       state_q;
    ctrl_state_t       state_d;
    logic              rx_error_q;
    logic [TO_W-1:0]   to_cnt;
    logic              push_req;
    logic              pop_ok;
    logic              err_evt;
    logic              ovr_evt;
    logic              to_clr;
    logic              to_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_OFF;
        else     state_q <= state_d;
    end

    // OFF waits for an idle receiver so a frame already in flight is never taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:  if (rx_en && !rx_busy) state_d = ST_IDLE;
            ST_IDLE: begin
                if (!rx_en)       state_d = ST_OFF;
                else if (rx_busy) state_d = ST_RECV;
            end
            ST_RECV: begin
                if (!rx_en)                     state_d = ST_OFF;
                else if (rx_ready || !rx_busy)  state_d = ST_IDLE;
            end
            default: state_d = ST_OFF;
        endcase
    end

    assign push_req = (state_q != ST_OFF) && rx_ready && !rx_error;
    assign pop_ok   = rd_en && !fifo_empty;
    assign err_evt  = rx_error && !rx_error_q && (state_q != ST_OFF);
    assign ovr_evt  = push_req && fifo_full && !rd_en;

    uart_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (rd_en),
        .flush (flush),
        .wdata (rx_data),
        .rdata (rd_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    assign irq_thresh = (thresh != '0) && (fifo_level >= thresh);

    // Same-cycle events take priority over clr_status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_error_q <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
            overrun    <= 1'b0;
        end else begin
            rx_error_q <= rx_error;
            if (err_evt) begin
                err_sticky <= 1'b1;
                if (clr_status)        err_cnt <= ERR_CNT_WIDTH'(1);
                else if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
            end else if (clr_status) begin
                err_sticky <= 1'b0;
                err_cnt    <= '0;
            end
            if (ovr_evt)         overrun <= 1'b1;
            else if (clr_status) overrun <= 1'b0;
        end
    end

    assign to_clr = push_req || pop_ok || flush || (state_q != ST_IDLE) || fifo_empty;
    assign to_hit = !to_clr && baud_en_16x && (to_cnt == TO_W'(TIMEOUT_TICKS - 1));

    // Character timeout: counts idle ticks with data waiting, saturating at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt      <= '0;
            irq_timeout <= 1'b0;
        end else begin
            if (to_clr)
                to_cnt <= '0;
            else if (baud_en_16x && (to_cnt != TO_W'(TIMEOUT_TICKS)))
                to_cnt <= to_cnt + TO_W'(1);
            if (to_hit)
                irq_timeout <= 1'b1;
            else if (pop_ok || flush || clr_status)
                irq_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized self-checking bench for uart_rx_ctrl against a queue-based model.
module tb_uart_rx_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned TO    = 640;
    localparam int unsigned EW    = 8;
    localparam int unsigned LW    = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          baud_en_16x, rx_en, flush, clr_status;
    logic [LW-1:0] thresh;
    logic [DW-1:0] rx_data;
    logic          rx_ready, rx_error, rx_busy, rd_en;
    logic [DW-1:0] rd_data;
    logic          fifo_empty, fifo_full;
    logic [LW-1:0] fifo_level;
    logic          irq_thresh, irq_timeout, overrun, err_sticky;
    logic [EW-1:0] err_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] q[$];
    int         m_err;

    always #5 clk = ~clk;

    uart_rx_ctrl #(
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_TICKS (TO),
        .ERR_CNT_WIDTH (EW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .baud_en_16x (baud_en_16x),
        .rx_en       (rx_en),
        .flush       (flush),
        .clr_status  (clr_status),
        .thresh      (thresh),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .rx_error    (rx_error),
        .rx_busy     (rx_busy),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .fifo_level  (fifo_level),
        .irq_thresh  (irq_thresh),
        .irq_timeout (irq_timeout),
        .overrun     (overrun),
        .err_sticky  (err_sticky),
        .err_cnt     (err_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic err, input logic fl, input logic rd);
        rx_busy = 1'b1; rx_error = err;
        step(); step();
        rx_ready = 1'b1; rx_data = d; flush = fl; rd_en = rd;
        step();
        rx_ready = 1'b0; rx_busy = 1'b0; rx_error = 1'b0; flush = 1'b0; rd_en = 1'b0; rx_data = '0;
        step();
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            baud_en_16x = 1'b1; step();
            baud_en_16x = 1'b0; step();
        end
    endtask

    task automatic pulse_flush_clr();
        flush = 1'b1; clr_status = 1'b1; step();
        flush = 1'b0; clr_status = 1'b0; step();
        q.delete();
        m_err = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        baud_en_16x = 0; rx_en = 0; flush = 0; clr_status = 0; thresh = LW'(1);
        rx_data = 0; rx_ready = 0; rx_error = 0; rx_busy = 0; rd_en = 0;
        step(); step();
        n_checks++;
        if ({fifo_empty, fifo_full, irq_thresh, irq_timeout, overrun, err_sticky} !== 6'b100000) begin
            $display("FAIL reset_flags: got %b want 100000",
                     {fifo_empty, fifo_full, irq_thresh, irq_timeout, overrun, err_sticky});
            n_fail++;
        end
        n_checks++;
        if (fifo_level !== '0) begin $display("FAIL reset_level: got %0d want 0", fifo_level); n_fail++; end
        n_checks++;
        if (rd_data !== '0) begin $display("FAIL reset_rd_data: got %0h want 0", rd_data); n_fail++; end
        n_checks++;
        if (err_cnt !== '0) begin $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); n_fail++; end
        rst = 1'b0;
        step();
        q.delete();
        m_err = 0;
    endtask

    task automatic test_basic();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h55; exp_b[1] = 8'hA3; exp_b[2] = 8'h0F;
        rx_en = 1'b1; step(); step();
        for (int i = 0; i < 3; i++) send_frame(exp_b[i], 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (fifo_level !== LW'(3)) begin $display("FAIL basic_level: got %0d want 3", fifo_level); n_fail++; end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rd_data !== exp_b[i]) begin
                $display("FAIL basic_read%0d: got %0h want %0h", i, rd_data, exp_b[i]); n_fail++;
            end
            rd_en = 1'b1; step(); rd_en = 1'b0;
        end
        n_checks++;
        if (fifo_empty !== 1'b1) begin $display("FAIL basic_empty: got %b want 1", fifo_empty); n_fail++; end
        rd_en = 1'b1; step(); rd_en = 1'b0; step();
        n_checks++;
        if ({fifo_empty, fifo_level} !== {1'b1, LW'(0)}) begin
            $display("FAIL pop_empty_ignored: got empty=%b level=%0d want 1/0", fifo_empty, fifo_level); n_fail++;
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            int k, p;
            logic [7:0] d;
            logic exp_irq;
            thresh = LW'($urandom_range(0, DEPTH));
            k = $urandom_range(1, 8);
            if (k > DEPTH - q.size()) k = DEPTH - q.size();
            for (int i = 0; i < k; i++) begin
                d = 8'($urandom);
                send_frame(d, 1'b0, 1'b0, 1'b0);
                q.push_back(d);
            end
            exp_irq = (thresh != 0) && (q.size() >= int'(thresh));
            n_checks++;
            if (fifo_level !== LW'(q.size())) begin
                $display("FAIL rand_level r%0d: got %0d want %0d", r, fifo_level, q.size()); n_fail++;
            end
            n_checks++;
            if (irq_thresh !== exp_irq) begin
                $display("FAIL rand_irq_thresh r%0d: got %b want %b (thresh %0d)", r, irq_thresh, exp_irq, thresh);
                n_fail++;
            end
            p = $urandom_range(0, q.size());
            for (int i = 0; i < p; i++) begin
                n_checks++;
                if (rd_data !== q[0]) begin
                    $display("FAIL rand_read r%0d: got %0h want %0h", r, rd_data, q[0]); n_fail++;
                end
                rd_en = 1'b1; step(); rd_en = 1'b0;
                void'(q.pop_front());
            end
        end
        thresh = '0;
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        pulse_flush_clr();
        for (int i = 0; i < DEPTH + 1; i++) begin
            d = 8'($urandom);
            send_frame(d, 1'b0, 1'b0, 1'b0);
            if (q.size() < DEPTH) q.push_back(d);
        end
        n_checks++;
        if ({fifo_full, overrun, fifo_level} !== {1'b1, 1'b1, LW'(DEPTH)}) begin
            $display("FAIL overflow_state: got full=%b ovr=%b level=%0d want 1/1/%0d",
                     fifo_full, overrun, fifo_level, DEPTH);
            n_fail++;
        end
        clr_status = 1'b1; step(); clr_status = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin $display("FAIL overrun_clear: got %b want 0", overrun); n_fail++; end
        d = 8'($urandom);
        send_frame(d, 1'b0, 1'b0, 1'b1);
        void'(q.pop_front());
        q.push_back(d);
        n_checks++;
        if ({fifo_full, overrun, fifo_level} !== {1'b1, 1'b0, LW'(DEPTH)}) begin
            $display("FAIL full_push_pop: got full=%b ovr=%b level=%0d want 1/0/%0d",
                     fifo_full, overrun, fifo_level, DEPTH);
            n_fail++;
        end
        while (q.size() > 0) begin
            n_checks++;
            if (rd_data !== q[0]) begin
                $display("FAIL overflow_drain: got %0h want %0h", rd_data, q[0]); n_fail++;
            end
            rd_en = 1'b1; step(); rd_en = 1'b0;
            void'(q.pop_front());
        end
        n_checks++;
        if (fifo_empty !== 1'b1) begin $display("FAIL overflow_empty: got %b want 1", fifo_empty); n_fail++; end
    endtask

    task automatic test_errors();
        pulse_flush_clr();
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        m_err = 1;
        n_checks++;
        if ({fifo_level, err_cnt, err_sticky} !== {LW'(0), EW'(1), 1'b1}) begin
            $display("FAIL err_frame: got level=%0d cnt=%0d sticky=%b want 0/1/1", fifo_level, err_cnt, err_sticky);
            n_fail++;
        end
        for (int i = 0; i < 300; i++) begin
            send_frame(8'($urandom), 1'b1, 1'b0, 1'b0);
            m_err = (m_err + 1 > 255) ? 255 : m_err + 1;
        end
        n_checks++;
        if (err_cnt !== EW'(m_err)) begin $display("FAIL err_saturate: got %0d want %0d", err_cnt, m_err); n_fail++; end
        clr_status = 1'b1; step(); clr_status = 1'b0;
        n_checks++;
        if ({err_cnt, err_sticky, overrun, irq_timeout} !== {EW'(0), 3'b000}) begin
            $display("FAIL clr_status: got cnt=%0d sticky=%b ovr=%b to=%b want 0/0/0/0",
                     err_cnt, err_sticky, overrun, irq_timeout);
            n_fail++;
        end
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        rx_busy = 1'b1; rx_error = 1'b1; clr_status = 1'b1; step(); clr_status = 1'b0;
        n_checks++;
        if ({err_cnt, err_sticky} !== {EW'(1), 1'b1}) begin
            $display("FAIL err_vs_clr: got cnt=%0d sticky=%b want 1/1", err_cnt, err_sticky); n_fail++;
        end
        step(); rx_ready = 1'b1; step();
        rx_ready = 1'b0; rx_busy = 1'b0; rx_error = 1'b0; step();
        rx_en = 1'b0; clr_status = 1'b1; step(); clr_status = 1'b0; step();
        rx_error = 1'b1; step(); rx_error = 1'b0; step();
        n_checks++;
        if ({err_cnt, err_sticky, fifo_level} !== {EW'(0), 1'b0, LW'(0)}) begin
            $display("FAIL err_while_off: got cnt=%0d sticky=%b level=%0d want 0/0/0", err_cnt, err_sticky, fifo_level);
            n_fail++;
        end
        rx_en = 1'b1; step(); step();
    endtask

    task automatic test_timeout();
        pulse_flush_clr();
        send_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
        do_ticks(TO - 1);
        n_checks++;
        if (irq_timeout !== 1'b0) begin $display("FAIL to_early1: got %b want 0", irq_timeout); n_fail++; end
        send_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
        do_ticks(TO - 1);
        n_checks++;
        if (irq_timeout !== 1'b0) begin $display("FAIL to_push_restart: got %b want 0", irq_timeout); n_fail++; end
        rd_en = 1'b1; step(); rd_en = 1'b0;
        do_ticks(TO - 1);
        n_checks++;
        if (irq_timeout !== 1'b0) begin $display("FAIL to_pop_restart: got %b want 0", irq_timeout); n_fail++; end
        baud_en_16x = 1'b1; step(); baud_en_16x = 1'b0;
        n_checks++;
        if (irq_timeout !== 1'b1) begin $display("FAIL to_rise: got %b want 1", irq_timeout); n_fail++; end
        do_ticks(5);
        n_checks++;
        if (irq_timeout !== 1'b1) begin $display("FAIL to_hold: got %b want 1", irq_timeout); n_fail++; end
        rd_en = 1'b1; step(); rd_en = 1'b0;
        n_checks++;
        if ({irq_timeout, fifo_empty} !== 2'b01) begin
            $display("FAIL to_pop_clear: got to=%b empty=%b want 0/1", irq_timeout, fifo_empty); n_fail++;
        end
        send_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
        do_ticks(TO);
        clr_status = 1'b1; step(); clr_status = 1'b0;
        n_checks++;
        if ({irq_timeout, fifo_level} !== {1'b0, LW'(1)}) begin
            $display("FAIL to_clr_status: got to=%b level=%0d want 0/1", irq_timeout, fifo_level); n_fail++;
        end
        send_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
        do_ticks(TO);
        flush = 1'b1; step(); flush = 1'b0;
        n_checks++;
        if ({irq_timeout, fifo_empty} !== 2'b01) begin
            $display("FAIL to_flush_clear: got to=%b empty=%b want 0/1", irq_timeout, fifo_empty); n_fail++;
        end
        q.delete();
    endtask

    task automatic test_enable();
        logic [7:0] d;
        rx_en = 1'b0; step();
        rx_busy = 1'b1; step();
        rx_en = 1'b1; step(); step();
        rx_ready = 1'b1; rx_data = 8'h3C; step();
        rx_ready = 1'b0; rx_busy = 1'b0; rx_data = '0; step();
        n_checks++;
        if (fifo_level !== LW'(0)) begin $display("FAIL en_while_busy: got level %0d want 0", fifo_level); n_fail++; end
        d = 8'($urandom);
        send_frame(d, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({fifo_level, rd_data} !== {LW'(1), d}) begin
            $display("FAIL en_next_frame: got level=%0d data=%0h want 1/%0h", fifo_level, rd_data, d); n_fail++;
        end
        rx_busy = 1'b1; step();
        rx_en = 1'b0; step();
        rx_ready = 1'b1; rx_data = 8'($urandom); step();
        rx_ready = 1'b0; rx_busy = 1'b0; step();
        n_checks++;
        if ({fifo_level, rd_data} !== {LW'(1), d}) begin
            $display("FAIL dis_midframe: got level=%0d data=%0h want 1/%0h", fifo_level, rd_data, d); n_fail++;
        end
        rd_en = 1'b1; step(); rd_en = 1'b0;
        n_checks++;
        if (fifo_empty !== 1'b1) begin $display("FAIL read_while_off: got empty %b want 1", fifo_empty); n_fail++; end
        rx_en = 1'b1; step(); step();
        send_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
        send_frame(8'($urandom), 1'b0, 1'b1, 1'b0);
        n_checks++;
        if ({fifo_empty, fifo_level} !== {1'b1, LW'(0)}) begin
            $display("FAIL flush_vs_push: got empty=%b level=%0d want 1/0", fifo_empty, fifo_level); n_fail++;
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        send_frame(8'($urandom), 1'b0, 1'b0, 1'b0);
        rx_busy = 1'b1; step();
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({fifo_empty, fifo_level, rd_data} !== {1'b1, LW'(0), DW'(0)}) begin
            $display("FAIL async_reset: got empty=%b level=%0d data=%0h want 1/0/0", fifo_empty, fifo_level, rd_data);
            n_fail++;
        end
        @(posedge clk); #1 rst = 1'b0;
        step();
        rx_ready = 1'b1; rx_data = 8'h77; step();
        rx_ready = 1'b0; rx_busy = 1'b0; step();
        n_checks++;
        if (fifo_level !== LW'(0)) begin $display("FAIL post_reset_frame: got level %0d want 0", fifo_level); n_fail++; end
        d = 8'($urandom);
        send_frame(d, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({fifo_level, rd_data} !== {LW'(1), d}) begin
            $display("FAIL post_reset_next: got level=%0d data=%0h want 1/%0h", fifo_level, rd_data, d); n_fail++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_overflow();
        test_errors();
        test_timeout();
        test_enable();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
